// File: rtl/lock_pkg.sv
// Shared definitions for the key-lock arbiter.
//   DEFAULT_KEY_WIDTH : default key width used by the arbiter
//   lock_entry_t      : lock-table entry layout {valid, key, owner}
//   clog2             : ceiling log2 for elaboration-time width math
package lock_pkg;

  localparam int unsigned DEFAULT_KEY_WIDTH = 32;
  // Owner field is wide enough for the largest supported pipeline count (8).
  localparam int unsigned OWNER_WIDTH = 3;

  typedef struct packed {
    logic                         valid;
    logic [DEFAULT_KEY_WIDTH-1:0] key;
    logic [OWNER_WIDTH-1:0]       owner;
  } lock_entry_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/lock_order_fifo.sv
// Per-pipeline FIFO of lock-table indices, oldest lock at the head.
//   clk_i/rst_i  : clock, asynchronous active-high reset
//   push_i       : append push_data_i (ignored when full)
//   pop_i        : drop the head entry (ignored when empty)
//   full_o       : Depth entries stored
//   empty_o      : no entries stored
//   head_o       : oldest stored index (valid when !empty_o)
//   count_o      : number of stored entries
module lock_order_fifo
  import lock_pkg::*;
#(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 4,
  localparam int unsigned CntW = clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [Width-1:0] head_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = (Depth > 1) ? clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    do_push  = push_i && !full_o;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + CntW'(do_push) - CntW'(do_pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read before it is written.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/key_lock_arbiter.sv
// Shared key-lock controller for NUM_PROCS update pipelines.
// Keeps a table of locked keys, services one obtain request per cycle in
// round-robin order (grant or blocked), and frees each pipeline's locks oldest
// first on release.
//   clk, reset            : clock, asynchronous active-high reset
//   proc_key              : key of pipeline p at [p*KEY_WIDTH +: KEY_WIDTH]
//   proc_obtain_key       : level request per pipeline
//   proc_key_grant        : 1-cycle pulse, lock acquired
//   proc_key_blocked      : 1-cycle pulse, key already locked
//   proc_key_release      : 1-cycle pulse, free pipeline's oldest lock
//   proc_key_release_ack  : 1-cycle pulse, one cycle after release
//   locks_available       : free entry exists and pipeline below its lock limit
//   locks_held            : number of valid table entries
//   lock_error            : sticky, release seen with no lock held
module key_lock_arbiter
  import lock_pkg::*;
#(
  parameter int unsigned NUM_PROCS      = 4,
  parameter int unsigned KEY_WIDTH      = DEFAULT_KEY_WIDTH,
  parameter int unsigned NUM_ENTRIES    = 16,
  parameter int unsigned LOCKS_PER_PROC = 4,
  localparam int unsigned HeldW = clog2(NUM_ENTRIES) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PROCS*KEY_WIDTH-1:0] proc_key,
  input  logic [NUM_PROCS-1:0]           proc_obtain_key,
  output logic [NUM_PROCS-1:0]           proc_key_grant,
  output logic [NUM_PROCS-1:0]           proc_key_blocked,
  input  logic [NUM_PROCS-1:0]           proc_key_release,
  output logic [NUM_PROCS-1:0]           proc_key_release_ack,
  output logic [NUM_PROCS-1:0]           locks_available,
  output logic [HeldW-1:0]               locks_held,
  output logic                           lock_error
);

  localparam int unsigned IdxW = (NUM_ENTRIES > 1) ? clog2(NUM_ENTRIES) : 1;
  localparam int unsigned OwnW = (NUM_PROCS > 1) ? clog2(NUM_PROCS) : 1;
  localparam int unsigned CntW = clog2(LOCKS_PER_PROC) + 1;

  typedef struct packed {
    logic                 valid;
    logic [KEY_WIDTH-1:0] key;
    logic [OwnW-1:0]      owner;
  } entry_t;

  entry_t [NUM_ENTRIES-1:0] table_q, table_d;
  logic   [OwnW-1:0]        rr_q, rr_d;
  logic   [NUM_PROCS-1:0]   grant_q, grant_d;
  logic   [NUM_PROCS-1:0]   blocked_q, blocked_d;
  logic   [NUM_PROCS-1:0]   ack_q, ack_d;
  logic   [NUM_PROCS-1:0]   avail_q, avail_d;
  logic   [HeldW-1:0]       held_q, held_d;
  logic                     lock_error_q, lock_error_d;

  logic [NUM_PROCS-1:0]           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [NUM_PROCS-1:0][IdxW-1:0] fifo_head;
  logic [NUM_PROCS-1:0][CntW-1:0] fifo_count;

  logic [NUM_PROCS-1:0] key_hit, eligible, serviceable;
  logic                 free_any;
  logic [IdxW-1:0]      free_idx;
  logic                 win_found;
  logic [OwnW-1:0]      win_idx, cand;
  logic [KEY_WIDTH-1:0] win_key;
  int unsigned          cnt_next;

  // Match, free-entry search and round-robin pick, all on the registered table.
  always_comb begin
    key_hit = '0;
    for (int unsigned p = 0; p < NUM_PROCS; p++) begin
      for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
        if (table_q[e].valid && table_q[e].key == proc_key[p*KEY_WIDTH +: KEY_WIDTH]) begin
          key_hit[p] = 1'b1;
        end
      end
    end

    free_any = 1'b0;
    free_idx = '0;
    for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
      if (!free_any && !table_q[e].valid) begin
        free_any = 1'b1;
        free_idx = IdxW'(e);
      end
    end

    // A pipeline being answered this cycle is still driving its old request.
    eligible = proc_obtain_key & ~(grant_q | blocked_q);
    for (int unsigned p = 0; p < NUM_PROCS; p++) begin
      serviceable[p] = eligible[p] & (key_hit[p] | (free_any & ~fifo_full[p]));
    end

    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_PROCS; i++) begin
      cand = OwnW'((32'(rr_q) + i) % NUM_PROCS);
      if (!win_found && serviceable[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end

    win_key = '0;
    for (int unsigned p = 0; p < NUM_PROCS; p++) begin
      if (OwnW'(p) == win_idx) begin
        win_key = proc_key[p*KEY_WIDTH +: KEY_WIDTH];
      end
    end

    rr_d = rr_q;
    if (win_found) begin
      rr_d = OwnW'((32'(win_idx) + 32'd1) % NUM_PROCS);
    end
  end

  // Table update, response pulses and registered status.
  always_comb begin
    table_d      = table_q;
    grant_d      = '0;
    blocked_d    = '0;
    fifo_push    = '0;
    fifo_pop     = proc_key_release & ~fifo_empty;
    ack_d        = proc_key_release;
    lock_error_d = lock_error_q | (|(proc_key_release & fifo_empty));

    for (int unsigned p = 0; p < NUM_PROCS; p++) begin
      // Owner check guards against clearing an entry this pipeline does not own.
      if (fifo_pop[p] && table_q[fifo_head[p]].owner == OwnW'(p)) begin
        table_d[fifo_head[p]].valid = 1'b0;
      end
    end

    // The allocated entry was free in table_q, so it never collides with a release.
    if (win_found) begin
      if (key_hit[win_idx]) begin
        blocked_d[win_idx] = 1'b1;
      end else begin
        grant_d[win_idx]         = 1'b1;
        fifo_push[win_idx]       = 1'b1;
        table_d[free_idx].valid = 1'b1;
        table_d[free_idx].key   = win_key;
        table_d[free_idx].owner = win_idx;
      end
    end

    held_d = '0;
    for (int unsigned e = 0; e < NUM_ENTRIES; e++) begin
      held_d = held_d + HeldW'(table_d[e].valid);
    end

    cnt_next = 0;
    avail_d  = '0;
    for (int unsigned p = 0; p < NUM_PROCS; p++) begin
      cnt_next   = 32'(fifo_count[p]) + 32'(fifo_push[p]) - 32'(fifo_pop[p]);
      avail_d[p] = (held_d < HeldW'(NUM_ENTRIES)) && (cnt_next < LOCKS_PER_PROC);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      table_q      <= '0;
      rr_q         <= '0;
      grant_q      <= '0;
      blocked_q    <= '0;
      ack_q        <= '0;
      avail_q      <= '1;
      held_q       <= '0;
      lock_error_q <= 1'b0;
    end else begin
      table_q      <= table_d;
      rr_q         <= rr_d;
      grant_q      <= grant_d;
      blocked_q    <= blocked_d;
      ack_q        <= ack_d;
      avail_q      <= avail_d;
      held_q       <= held_d;
      lock_error_q <= lock_error_d;
    end
  end

  for (genvar p = 0; p < NUM_PROCS; p++) begin : g_fifo
    lock_order_fifo #(
      .Depth (LOCKS_PER_PROC),
      .Width (IdxW)
    ) u_fifo (
      .clk_i       (clk),
      .rst_i       (reset),
      .push_i      (fifo_push[p]),
      .push_data_i (free_idx),
      .pop_i       (fifo_pop[p]),
      .full_o      (fifo_full[p]),
      .empty_o     (fifo_empty[p]),
      .head_o      (fifo_head[p]),
      .count_o     (fifo_count[p])
    );
  end

  assign proc_key_grant       = grant_q;
  assign proc_key_blocked     = blocked_q;
  assign proc_key_release_ack = ack_q;
  assign locks_available      = avail_q;
  assign locks_held           = held_q;
  assign lock_error           = lock_error_q;

endmodule

// File: doc/key_lock_arbiter.md
Name: key_lock_arbiter

Overview:
- Shared key-lock controller serving the lock handshake of up to NUM_PROCS update pipelines.
- Keeps a table of currently locked keys and arbitrates round-robin among the pipelines' obtain requests, one per cycle.
- Grants or blocks each serviced request; frees each pipeline's locks in FIFO order on release.
- Guarantees that no two in-flight pipeline updates touch the same key.

Parameters:
NUM_PROCS, 4, number of requesting pipelines (1..8)
KEY_WIDTH, 32, key width in bits
NUM_ENTRIES, 16, total lock-table entries shared by all pipelines
LOCKS_PER_PROC, 4, maximum locks held concurrently by one pipeline (power of 2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
proc_key  in  NUM_PROCS*KEY_WIDTH  key of pipeline p at slice [p*KEY_WIDTH +: KEY_WIDTH]
proc_obtain_key  in  NUM_PROCS  level request; held with key stable until grant or blocked
proc_key_grant  out  NUM_PROCS  1-cycle pulse: lock acquired
proc_key_blocked  out  NUM_PROCS  1-cycle pulse: key already locked, retry later
proc_key_release  in  NUM_PROCS  1-cycle pulse: free pipeline's oldest held lock
proc_key_release_ack  out  NUM_PROCS  1-cycle pulse, one cycle after release
locks_available  out  NUM_PROCS  free table entry exists AND pipeline below LOCKS_PER_PROC
locks_held  out  log2(NUM_ENTRIES)+1  number of valid table entries
lock_error  out  1  sticky: release with no lock held

Behaviour:
- Reset (async): table valid bits 0; order FIFOs empty; round-robin pointer 0; all pulse outputs 0; lock_error 0; locks_held 0; locks_available all 1.
- Table entry: valid, key, owner. Per-pipeline order FIFO stores entry indices, depth LOCKS_PER_PROC.
- Eligibility, cycle N, pipeline p: obtain high; grant/blocked not high for p in cycle N (requester drops obtain on response).
- Serviceable: eligible AND (key matches a valid entry OR (free entry exists AND p's FIFO not full)).
- Arbitration: among serviceable pipelines, first at or after the rr pointer wins; pointer then moves to winner+1 mod NUM_PROCS.
- Non-serviceable requests wait and are not responded to.
- Matching uses the table state registered at the start of cycle N; the key compare spans all valid entries regardless of owner.
- Match: proc_key_blocked[p]=1 in cycle N+1. A pipeline re-requesting its own held key is blocked.
- No match: the lowest-index free entry is written {1,key,p}; its index is pushed to FIFO p; proc_key_grant[p]=1 in cycle N+1. The entry is visible to matching from cycle N+1.
- Latency: 1 cycle request-to-response. Throughput: one obtain serviced per cycle.
- Release pulse on p in cycle N: pop FIFO p and clear that entry's valid bit at the end of cycle N; proc_key_release_ack[p]=1 in cycle N+1.
- Releases from all pipelines in the same cycle are processed in parallel; entries are distinct.
- Release with FIFO p empty: ack still pulses; lock_error is set; no table change.
- Release of key K in the same cycle as an obtain of K: the obtain sees K held and is blocked.
- Release of entry E in the same cycle as an allocation: E is not reusable until cycle N+1.
- locks_held and locks_available are registered and reflect the table after the cycle's updates (1-cycle delay).
- Reset mid-operation: all locks are dropped immediately and all pulses are cleared; pending requests are re-arbitrated after reset.

Decomposition:
- Shared package lock_pkg: KEY_WIDTH default; entry struct typedef {valid, key, owner}; function clog2.
- One sub-module: lock_order_fifo, a per-pipeline index FIFO (push, pop, full, empty, head), instantiated NUM_PROCS times via generate.
- Match/priority encoders and round-robin logic stay in the top module.

Test Plan:
- Single grant: p0 obtains key 0x10 -> grant[0] next cycle, locks_held=1; p1 then obtains 0x10 -> blocked[1]; p0 releases -> ack[0] next cycle; p1 retries 0x10 -> grant[1].
- Round-robin: p0..p3 all request distinct keys 0x1..0x4 held continuously -> grants in order p0,p1,p2,p3 on 4 consecutive cycles.
- Same-cycle conflict: p0 releases 0x20 while p2 requests 0x20 -> blocked[2]; p2 retry next cycle -> grant[2].
- Capacity: NUM_ENTRIES=16, LOCKS_PER_PROC=4, 4 pipes each lock 4 keys -> locks_held=16, locks_available=0000; further request 0x99 gets no response until any release, then grant.
- Per-proc limit: p0 holds 4 locks -> locks_available[0]=0 while [1]=1; p0's 5th request is not serviced; p0 release -> oldest key freed (verify by p1 obtaining p0's first key -> grant).
- Error/reset: release on p3 with no locks -> ack[3], lock_error=1; assert reset mid-traffic -> all outputs and the table at reset values asynchronously.
